// File: rtl/vec_rec_pkg.sv
// Shared types and constants for the vec_record_writer slice.
//   state_e  : formatter FSM states
//   CHAR_*   : ASCII bytes of the record format
//   rec_len  : bytes per record for a given field width
//   bit_char : ASCII digit for one sample bit
package vec_rec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT_A,
    ST_SEP1,
    ST_EMIT_B,
    ST_SEP2,
    ST_EMIT_C,
    ST_EOL
  } state_e;

  localparam logic [7:0] CHAR_0   = 8'h30;
  localparam logic [7:0] CHAR_1   = 8'h31;
  localparam logic [7:0] CHAR_SEP = 8'h2C;
  localparam logic [7:0] CHAR_EOL = 8'h0A;

  function automatic int unsigned rec_len(input int unsigned width);
    return 3 * width + 3;
  endfunction

  // Anything that is not a clean 1 prints as '0'.
  function automatic logic [7:0] bit_char(input logic b);
    return (b === 1'b1) ? CHAR_1 : CHAR_0;
  endfunction

endpackage

// File: rtl/vec_rec_fifo.sv
// Synchronous sample FIFO with level counter.
//   clk, rst            : clock, async active-high reset (clears pointers/level)
//   wr_en_i, wr_data_i  : write request; ignored when full
//   rd_en_i, rd_data_o  : pop request; rd_data_o shows the head entry
//   full_o, empty_o     : derived from the registered level
//   level_o             : number of stored entries
module vec_rec_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [DW-1:0]              wr_data_i,
  input  logic                       rd_en_i,
  output logic [DW-1:0]              rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push, pop;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign level_d   = level_q + LVL_W'(push) - LVL_W'(pop);

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset; the level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/vec_record_writer.sv
// Serializes (A,B,C) samples as ASCII records "AAAA,BBBB,CCCC\n", MSB first.
//   clk, rst                         : clock, async active-high reset
//   smp_valid/smp_ready, smp_a/b/c   : sample input handshake and fields
//   out_valid/out_ready, out_data    : registered byte stream
//   fifo_level                       : samples waiting in the FIFO
//   rec_count                        : completed records, wraps at 2^16
module vec_record_writer
  import vec_rec_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   smp_valid,
  output logic                   smp_ready,
  input  logic [WIDTH-1:0]       smp_a,
  input  logic [WIDTH-1:0]       smp_b,
  input  logic [WIDTH-1:0]       smp_c,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            rec_count
);

  localparam int unsigned DW    = 3 * WIDTH;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [DW-1:0]    rec_q, rec_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [15:0]      rec_count_q, rec_count_d;

  logic             fifo_full, fifo_empty, pop_c, load_c, xfer;
  logic [DW-1:0]    fifo_rd_data;
  logic [WIDTH-1:0] fld_a, fld_b, fld_c;

  vec_rec_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (smp_valid),
    .wr_data_i ({smp_a, smp_b, smp_c}),
    .rd_en_i   (pop_c),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign smp_ready = !fifo_full;
  assign xfer      = out_valid_q && out_ready;
  assign idx_nxt   = idx_q - IDX_W'(1);
  assign fld_a     = rec_q[DW-1 -: WIDTH];
  assign fld_b     = rec_q[2*WIDTH-1 -: WIDTH];
  assign fld_c     = rec_q[WIDTH-1:0];

  // Formatter: each state owns the byte currently in out_data_q and
  // preloads the next byte on transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rec_d       = rec_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rec_count_d = rec_count_q;
    load_c      = 1'b0;
    pop_c       = 1'b0;

    case (state_q)
      ST_IDLE: load_c = !fifo_empty;
      ST_EMIT_A: if (xfer) begin
        if (idx_q == '0) begin
          state_d    = ST_SEP1;
          out_data_d = CHAR_SEP;
        end else begin
          idx_d      = idx_nxt;
          out_data_d = bit_char(fld_a[idx_nxt]);
        end
      end
      ST_SEP1: if (xfer) begin
        state_d    = ST_EMIT_B;
        idx_d      = IDX_MAX;
        out_data_d = bit_char(fld_b[IDX_MAX]);
      end
      ST_EMIT_B: if (xfer) begin
        if (idx_q == '0) begin
          state_d    = ST_SEP2;
          out_data_d = CHAR_SEP;
        end else begin
          idx_d      = idx_nxt;
          out_data_d = bit_char(fld_b[idx_nxt]);
        end
      end
      ST_SEP2: if (xfer) begin
        state_d    = ST_EMIT_C;
        idx_d      = IDX_MAX;
        out_data_d = bit_char(fld_c[IDX_MAX]);
      end
      ST_EMIT_C: if (xfer) begin
        if (idx_q == '0) begin
          state_d    = ST_EOL;
          out_data_d = CHAR_EOL;
        end else begin
          idx_d      = idx_nxt;
          out_data_d = bit_char(fld_c[idx_nxt]);
        end
      end
      ST_EOL: if (xfer) begin
        rec_count_d = rec_count_q + 16'd1;
        if (fifo_empty) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_data_d  = 8'h00;
        end else begin
          load_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop the next sample and present the MSB of A immediately (no bubble).
    if (load_c) begin
      pop_c       = 1'b1;
      rec_d       = fifo_rd_data;
      state_d     = ST_EMIT_A;
      idx_d       = IDX_MAX;
      out_valid_d = 1'b1;
      out_data_d  = bit_char(fifo_rd_data[DW-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rec_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      rec_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rec_q       <= rec_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rec_count = rec_count_q;

endmodule
